duty_wave_sequencer: RTL and testbench

DUTY_WAVE_SEQUENCER -- requirements
Module: duty_wave_sequencer

---
 rtl/duty_wave_pkg.sv | 27 ++
 rtl/pwm_core.sv | 33 +++
 rtl/duty_wave_sequencer.sv | 178 +++++++++++++++++
 tb/tb_duty_wave_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/duty_wave_pkg.sv
// Shared encodings for the duty wave sequencer: waveform modes, FSM states,
// default widths and the mode-to-start-state mapping.
package duty_wave_pkg;

  localparam int DUTY_W_DEF = 7;
  localparam int DIV_W_DEF  = 6;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_TRI  = 2'b01;
  localparam logic [1:0] MODE_SAW  = 2'b10;
  localparam logic [1:0] MODE_HOLD = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_UP   = 2'd1;
  localparam logic [1:0] ST_DOWN = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  // Ramping modes begin climbing from zero; HOLD parks at the peak level.
  function automatic logic [1:0] start_state(input logic [1:0] mode);
    case (mode)
      MODE_TRI, MODE_SAW: start_state = ST_UP;
      MODE_HOLD:          start_state = ST_HOLD;
      default:            start_state = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/pwm_core.sv
// Free-running PWM counter with a duty latch that only reloads at the end of a
// period, so the output never glitches when the sequencer duty moves mid-period.
module pwm_core
  import duty_wave_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_out,
  output logic              period_tick
);

  logic [DUTY_W-1:0] cnt;
  logic [DUTY_W-1:0] latched;

  assign period_tick = &cnt;
  assign pwm_out     = (cnt < latched);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      latched <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (period_tick) begin
        latched <= duty;
      end
    end
  end

endmodule

// File: rtl/duty_wave_sequencer.sv
// Duty-cycle waveform sequencer (triangle / sawtooth / hold) driving a PWM core.
// Define WAVE_SAWTOOTH_EN to build sawtooth support; otherwise mode 10 acts as OFF.
module duty_wave_sequencer
  import duty_wave_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [1:0]        cfg_mode,
  input  logic [3:0]        cfg_step,
  input  logic [DUTY_W-1:0] cfg_peak,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [DUTY_W-1:0] duty_out,
  output logic              pwm_out,
  output logic              period_tick
);

  function automatic logic [1:0] effective_mode(input logic [1:0] mode);
`ifdef WAVE_SAWTOOTH_EN
    effective_mode = mode;
`else
    effective_mode = (mode == MODE_SAW) ? MODE_OFF : mode;
`endif
  endfunction

  logic              pending;
  logic [1:0]        sh_mode;
  logic [3:0]        sh_step;
  logic [DUTY_W-1:0] sh_peak;
  logic [DIV_W-1:0]  sh_div;

  logic [1:0]        act_mode;
  logic [3:0]        act_step;
  logic [DUTY_W-1:0] act_peak;
  logic [DIV_W-1:0]  act_div;

  logic [DIV_W-1:0]  presc;
  logic [1:0]        state;
  logic [DUTY_W-1:0] duty;

  logic [1:0]        mode_eff;
  logic              running;
  logic              step_tick;
  logic              apply;
  logic              saw_wrap;
  logic [DUTY_W:0]   step_ext;
  logic [DUTY_W:0]   peak_ext;
  logic [DUTY_W:0]   sum;
  logic [DUTY_W-1:0] next_duty;
  logic [1:0]        next_state;

  assign mode_eff  = effective_mode(act_mode);
  assign running   = enable && (mode_eff != MODE_OFF);
  assign step_tick = (presc == act_div);
  assign apply     = pending && period_tick;
  assign cfg_ready = !pending;
  assign duty_out  = duty;

  // One extra bit of headroom so duty+step can be compared against peak without wrapping.
  assign step_ext = {{(DUTY_W-3){1'b0}}, act_step};
  assign peak_ext = {1'b0, act_peak};
  assign sum      = {1'b0, duty} + step_ext;

`ifdef WAVE_SAWTOOTH_EN
  assign saw_wrap = (mode_eff == MODE_SAW) && (duty >= act_peak);
`else
  assign saw_wrap = 1'b0;
`endif

  always_comb begin
    next_duty  = duty;
    next_state = state;
    if (!running) begin
      next_duty  = '0;
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          next_duty  = '0;
          next_state = start_state(mode_eff);
        end
        ST_HOLD: next_duty = act_peak;
        ST_UP: begin
          if (step_tick) begin
            if (act_peak == '0) begin
              next_duty = '0;
            end else if (act_step != 4'd0) begin
              if (saw_wrap) begin
                next_duty = '0;
              end else if (sum >= peak_ext) begin
                next_duty = act_peak;
                if (mode_eff == MODE_TRI) begin
                  next_state = ST_DOWN;
                end
              end else begin
                next_duty = sum[DUTY_W-1:0];
              end
            end
          end
        end
        ST_DOWN: begin
          if (step_tick) begin
            if (act_peak == '0) begin
              next_duty = '0;
            end else if (act_step != 4'd0) begin
              if ({1'b0, duty} <= step_ext) begin
                next_duty  = '0;
                next_state = ST_UP;
              end else begin
                next_duty = duty - step_ext[DUTY_W-1:0];
              end
            end
          end
        end
        default: begin
          next_duty  = '0;
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  // A pending shadow is only swapped in at a period boundary; that cycle restarts the waveform.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      pending  <= 1'b0;
      sh_mode  <= MODE_OFF;
      sh_step  <= '0;
      sh_peak  <= '0;
      sh_div   <= '0;
      act_mode <= MODE_OFF;
      act_step <= '0;
      act_peak <= '0;
      act_div  <= '0;
      presc    <= '0;
      state    <= ST_IDLE;
      duty     <= '0;
    end else begin
      if (apply) begin
        pending  <= 1'b0;
        act_mode <= sh_mode;
        act_step <= sh_step;
        act_peak <= sh_peak;
        act_div  <= sh_div;
        presc    <= '0;
        duty     <= '0;
        state    <= enable ? start_state(effective_mode(sh_mode)) : ST_IDLE;
      end else begin
        if (cfg_valid && cfg_ready) begin
          pending <= 1'b1;
          sh_mode <= cfg_mode;
          sh_step <= cfg_step;
          sh_peak <= cfg_peak;
          sh_div  <= cfg_div;
        end
        presc <= (!running || step_tick) ? '0 : presc + 1'b1;
        duty  <= next_duty;
        state <= next_state;
      end
    end
  end

  pwm_core #(
    .DUTY_W(DUTY_W)
  ) u_pwm_core (
    .sysclk      (sysclk),
    .reset       (reset),
    .duty        (duty),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

endmodule

// File: tb/tb_duty_wave_sequencer.sv
// Directed bench for duty_wave_sequencer; sawtooth expectations follow WAVE_SAWTOOTH_EN.
module tb_duty_wave_sequencer;

  localparam int DUTY_W = 7;
  localparam int DIV_W  = 6;

  logic              sysclk = 1'b0;
  logic              reset;
  logic              enable;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_mode;
  logic [3:0]        cfg_step;
  logic [DUTY_W-1:0] cfg_peak;
  logic [DIV_W-1:0]  cfg_div;
  logic [DUTY_W-1:0] duty_out;
  logic              pwm_out;
  logic              period_tick;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int saw_exp[6];

  always #5 sysclk = ~sysclk;

  duty_wave_sequencer #(
    .DUTY_W(DUTY_W),
    .DIV_W (DIV_W)
  ) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_mode    (cfg_mode),
    .cfg_step    (cfg_step),
    .cfg_peak    (cfg_peak),
    .cfg_div     (cfg_div),
    .duty_out    (duty_out),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input logic [3:0] step,
                               input logic [DUTY_W-1:0] peak, input logic [DIV_W-1:0] div);
    cfg_mode  = mode;
    cfg_step  = step;
    cfg_peak  = peak;
    cfg_div   = div;
    cfg_valid = 1'b1;
    tick(1);
    cfg_valid = 1'b0;
  endtask

  // Park on the cycle where period_tick is high; the next edge applies any pending shadow.
  task automatic waitPeriod();
    int k;
    k = 0;
    while (period_tick !== 1'b1 && k < 300) begin
      tick(1);
      k++;
    end
    checkOutput("period_tick_seen", period_tick, 1);
  endtask

  initial begin
`ifdef WAVE_SAWTOOTH_EN
    saw_exp = '{4, 8, 12, 16, 0, 4};
`else
    saw_exp = '{0, 0, 0, 0, 0, 0};
`endif
    reset     = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_mode  = 2'b00;
    cfg_step  = 4'd0;
    cfg_peak  = '0;
    cfg_div   = '0;
    #2;
    checkOutput("rst_duty", duty_out, 0);
    checkOutput("rst_pwm", pwm_out, 0);
    checkOutput("rst_period_tick", period_tick, 0);
    checkOutput("rst_cfg_ready", cfg_ready, 1);
    @(posedge sysclk);
    #1;
    reset  = 1'b0;
    enable = 1'b1;

    // Triangle, step 2, peak 62, one step per cycle
    applyStimulus(2'b01, 4'd2, 7'd62, 6'd0);
    checkOutput("cfg_ready_pending", cfg_ready, 0);
    checkOutput("idle_duty", duty_out, 0);
    waitPeriod();
    tick(1);
    checkOutput("tri_apply_duty", duty_out, 0);
    checkOutput("tri_apply_ready", cfg_ready, 1);
    for (int i = 1; i <= 31; i++) begin
      tick(1);
      checkOutput("tri_up", duty_out, 2 * i);
    end
    for (int i = 1; i <= 31; i++) begin
      tick(1);
      checkOutput("tri_down", duty_out, 62 - 2 * i);
    end
    tick(1);
    checkOutput("tri_rebound", duty_out, 2);

    // cfg_valid held high mid-period; peak 63 exercises the clamp
    cfg_mode  = 2'b01;
    cfg_step  = 4'd2;
    cfg_peak  = 7'd63;
    cfg_div   = 6'd0;
    cfg_valid = 1'b1;
    tick(1);
    checkOutput("held_ready_low", cfg_ready, 0);
    waitPeriod();
    checkOutput("held_ready_at_tick", cfg_ready, 0);
    cfg_valid = 1'b0;
    tick(1);
    checkOutput("switch_step_suppressed", duty_out, 0);
    checkOutput("switch_ready", cfg_ready, 1);
    tick(31);
    checkOutput("clamp_pre", duty_out, 62);
    tick(1);
    checkOutput("clamp_peak", duty_out, 63);
    tick(1);
    checkOutput("clamp_down", duty_out, 61);

    // Prescaler div=63: 64 cycles per step, 128-cycle PWM period
    applyStimulus(2'b01, 4'd2, 7'd62, 6'd63);
    waitPeriod();
    tick(1);
    checkOutput("div_apply", duty_out, 0);
    tick(63);
    checkOutput("div_hold63", duty_out, 0);
    tick(1);
    checkOutput("div_step64", duty_out, 2);
    tick(63);
    checkOutput("div_hold127", duty_out, 2);
    checkOutput("period_tick_127", period_tick, 1);
    tick(1);
    checkOutput("div_step128", duty_out, 4);
    checkOutput("period_tick_128", period_tick, 0);
    checkOutput("pwm_cnt0", pwm_out, 1);
    tick(1);
    checkOutput("pwm_cnt1", pwm_out, 1);
    tick(1);
    checkOutput("pwm_cnt2", pwm_out, 0);
    tick(125);
    checkOutput("period_tick_255", period_tick, 1);
    checkOutput("div_hold255", duty_out, 6);
    tick(1);
    checkOutput("div_step256", duty_out, 8);
    checkOutput("pwm_next_period", pwm_out, 1);

    // Enable dropped mid-ramp at duty 40, then restored
    applyStimulus(2'b01, 4'd2, 7'd62, 6'd0);
    waitPeriod();
    tick(1);
    tick(20);
    checkOutput("ramp_at_40", duty_out, 40);
    enable = 1'b0;
    tick(1);
    checkOutput("disable_duty", duty_out, 0);
    tick(107);
    checkOutput("disable_pwm_cnt0", pwm_out, 0);
    tick(2);
    checkOutput("disable_pwm_cnt2", pwm_out, 0);
    enable = 1'b1;
    tick(1);
    checkOutput("reenable_start", duty_out, 0);
    tick(1);
    checkOutput("reenable_2", duty_out, 2);
    tick(1);
    checkOutput("reenable_4", duty_out, 4);

    // Mode 10: sawtooth when built in, otherwise OFF
    applyStimulus(2'b10, 4'd4, 7'd16, 6'd0);
    waitPeriod();
    tick(1);
    checkOutput("saw_apply", duty_out, 0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      checkOutput("saw_seq", duty_out, saw_exp[i]);
    end

    // HOLD: duty parks at peak, ticks ignored
    applyStimulus(2'b11, 4'd3, 7'd50, 6'd0);
    waitPeriod();
    tick(1);
    checkOutput("hold_apply", duty_out, 0);
    tick(1);
    checkOutput("hold_level", duty_out, 50);
    tick(5);
    checkOutput("hold_steady", duty_out, 50);

    // Reset mid-ramp with a configuration pending
    applyStimulus(2'b01, 4'd2, 7'd62, 6'd0);
    waitPeriod();
    tick(1);
    tick(10);
    checkOutput("pre_reset_duty", duty_out, 20);
    applyStimulus(2'b11, 4'd1, 7'd50, 6'd0);
    checkOutput("pre_reset_pending", cfg_ready, 0);
    reset = 1'b1;
    #1;
    checkOutput("midreset_duty", duty_out, 0);
    checkOutput("midreset_ready", cfg_ready, 1);
    checkOutput("midreset_pwm", pwm_out, 0);
    checkOutput("midreset_period_tick", period_tick, 0);
    @(posedge sysclk);
    #1;
    reset = 1'b0;
    waitPeriod();
    tick(2);
    checkOutput("post_reset_off", duty_out, 0);
    checkOutput("post_reset_ready", cfg_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
